// File: rtl/block_mem_pkg.sv
// block_mem_pkg: shared types and constants for the block memory port agent.
//   ADDR_W / DATA_W        : word address and data widths of a controller port
//   BLOCK_SEL_MSB / _LSB   : address bits that select one of the 16 memory blocks
//   state_t                : request sequencer states
//   req_t                  : one buffered client command
package block_mem_pkg;

  localparam int ADDR_W        = 12;
  localparam int DATA_W        = 32;
  localparam int BLOCK_SEL_MSB = 11;
  localparam int BLOCK_SEL_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Block index of a word address; two ports touching the same block conflict.
  function automatic logic [BLOCK_SEL_MSB-BLOCK_SEL_LSB:0] block_of(input logic [ADDR_W-1:0] addr);
    return addr[BLOCK_SEL_MSB:BLOCK_SEL_LSB];
  endfunction

endpackage

// File: rtl/block_mem_req_fifo.sv
// block_mem_req_fifo: synchronous command buffer of req_t entries.
//   clk, reset      : clock and synchronous active-high reset (flushes the buffer)
//   push, push_data : write one entry (ignored when full)
//   pop, pop_data   : pop_data shows the oldest entry; pop removes it (ignored when empty)
//   full, empty     : occupancy flags
module block_mem_req_fifo
  import block_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/block_mem_requester.sv
// block_mem_requester: initiator-side agent in front of one block memory
// controller port. Buffers client commands, presents each to the controller,
// holds it until granted (or abandons it after MAX_RETRY ungranted cycles) and
// returns the result on a valid/ready response channel.
// Widths come from block_mem_pkg so the buffered struct and the ports agree.
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : client command channel
//   rsp_valid/ready/write/rdata/error: client response channel
//   rd_addr, rd_data, rd_enable: controller read address, data and read grant
//   wr_addr, wr_data, wr_enable, wr_grant: controller write request and grant
//   busy                       : commands buffered or a request in flight
//   conflict_cnt               : saturating count of ungranted WAIT cycles
module block_mem_requester
  import block_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  input  logic              wr_grant,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_t             state;
  req_t               cmd_req;
  req_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               req_write;
  logic               grant;
  logic [RETRY_W-1:0] retry_cnt;

  assign cmd_ready = !fifo_full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign cmd_req   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign busy      = !fifo_empty || (state != IDLE);
  assign rsp_valid = (state == RESP);
  // Only the grant matching the request type counts.
  assign grant     = req_write ? wr_grant : rd_enable;

  block_mem_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(cmd_req),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (pop) req_write <= head.write;
  end

  // Controller-facing outputs are loaded on the pop edge so they are already
  // valid during ISSUE; they then hold until the next request of that type.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      retry_cnt    <= '0;
      conflict_cnt <= '0;
      wr_enable    <= 1'b0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rsp_write    <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            retry_cnt <= '0;
            if (head.write) begin
              wr_addr   <= head.addr;
              wr_data   <= head.wdata;
              wr_enable <= 1'b1;
            end else begin
              rd_addr <= head.addr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (grant) begin
            rsp_write <= req_write;
            rsp_rdata <= req_write ? '0 : rd_data;
            rsp_error <= 1'b0;
            wr_enable <= 1'b0;
            state     <= RESP;
          end else begin
            if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            if (retry_cnt == RETRY_LAST) begin
              rsp_write <= req_write;
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              wr_enable <= 1'b0;
              state     <= RESP;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
            end
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_requester.sv
module tb_block_mem_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_enable;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_enable;
  logic        wr_grant;
  logic        busy;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  block_mem_requester #(
    .FIFO_DEPTH(4),
    .MAX_RETRY (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_enable   (rd_enable),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_enable   (wr_enable),
    .wr_grant    (wr_grant),
    .busy        (busy),
    .conflict_cnt(conflict_cnt)
  );

  // Controller port model: reads every cycle, grants are registered
  // (grant in cycle N+1 for what was presented in cycle N); clearing 'allow'
  // withholds grants to emulate same-block conflicts.
  logic        allow;
  logic [31:0] mem [0:4095];

  always @(posedge clk) begin
    rd_data   <= mem[rd_addr];
    rd_enable <= allow;
    wr_grant  <= allow && wr_enable;
  end

  // Behavioural model: responses come back in command order; each carries the
  // command type, memory contents for a granted read, zero otherwise.
  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        err;
  } cmd_t;

  cmd_t exp_q[$];
  logic exp_err;
  bit   acc;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_cycle();
    cmd_t        c;
    logic [31:0] want;
    acc = 1'b0;
    if (reset) begin
      exp_q.delete();
      return;
    end
    if (wr_enable) begin
      n_cmp++;
      if (exp_q.size() == 0 || !exp_q[0].write) begin
        n_fail++;
        $display("FAIL wr_enable_spurious: got wr_enable=1, want 0 (cycle %0d)", cyc);
      end else begin
        n_cmp--;
        check("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
        check("wr_data", wr_data, exp_q[0].wdata);
      end
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1, want 0 (cycle %0d)", cyc);
      end else begin
        c    = exp_q[0];
        want = (c.write || c.err) ? 32'h0 : mem[c.addr];
        check("rsp_write", 32'(rsp_write), 32'(c.write));
        check("rsp_error", 32'(rsp_error), 32'(c.err));
        check("rsp_rdata", rsp_rdata, want);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
    if (cmd_valid && cmd_ready) begin
      c.write = cmd_write;
      c.addr  = cmd_addr;
      c.wdata = cmd_wdata;
      c.err   = exp_err;
      exp_q.push_back(c);
      acc = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic e, output int acc_cyc);
    int k;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    exp_err   = e;
    k = 0;
    do begin
      step();
      k++;
    end while (!acc && k < 50);
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, want accept of addr %h", a);
    end
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    int k;
    k = 0;
    while (!rsp_valid && k < budget) begin
      step();
      k++;
    end
    if (!rsp_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: got rsp_valid=0 after %0d cycles, want 1", budget);
    end
    at = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, k, n_we;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;
    mem[12'h050] = 32'hBBBB_BBBB;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    exp_err   = 1'b0;
    rsp_ready = 1'b1;
    allow     = 1'b1;

    // Reset state
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_wr_enable", 32'(wr_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_conflict_cnt", 32'(conflict_cnt), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_error", 32'(rsp_error), 0);
    check("rst_rsp_write", 32'(rsp_write), 0);
    reset = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Write 0x257 <- AAAA_AAAA, granted one cycle after ISSUE
    send(1'b1, 12'h257, 32'hAAAA_AAAA, 1'b0, t0);
    n_we = 0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      step();
      k++;
      if (wr_enable) n_we++;
    end
    check("t1_latency", 32'(cyc - t0), 3);
    check("t1_wr_enable_cycles", 32'(n_we), 2);
    check("t1_rsp_error", 32'(rsp_error), 0);
    check("t1_rsp_write", 32'(rsp_write), 1);
    check("t1_wr_addr", 32'(wr_addr), 32'h257);
    step();
    check("t1_idle_busy", 32'(busy), 0);

    // Read 0x050 -> BBBB_BBBB
    send(1'b0, 12'h050, 32'h0, 1'b0, t0);
    wait_rsp(20, t1);
    check("t2_latency", 32'(t1 - t0), 3);
    check("t2_rsp_rdata", rsp_rdata, 32'hBBBB_BBBB);
    check("t2_rsp_write", 32'(rsp_write), 0);
    step();

    // Read 0x00F with grant withheld for 3 WAIT cycles
    allow = 1'b0;
    send(1'b0, 12'h00F, 32'h0, 1'b0, t0);
    repeat (4) begin
      step();
      check("t3_rd_addr_held", 32'(rd_addr), 32'h00F);
    end
    allow = 1'b1;
    wait_rsp(20, t1);
    check("t3_latency", 32'(t1 - t0), 6);
    check("t3_conflict_cnt", 32'(conflict_cnt), 3);
    check("t3_rsp_rdata", rsp_rdata, 32'h5A00_000F);
    step();

    // Grant withheld permanently: abandoned after 15 WAIT cycles, queued write follows
    allow = 1'b0;
    send(1'b0, 12'h123, 32'h0, 1'b1, t0);
    send(1'b1, 12'h300, 32'hDEAD_BEEF, 1'b0, t2);
    check("t4_second_accept", 32'(t2 - t0), 1);
    wait_rsp(40, t1);
    check("t4_latency", 32'(t1 - t0), 17);
    check("t4_rsp_error", 32'(rsp_error), 1);
    check("t4_rsp_rdata", rsp_rdata, 0);
    check("t4_conflict_cnt", 32'(conflict_cnt), 18);
    allow = 1'b1;
    step();
    t0 = cyc;
    wait_rsp(20, t1);
    check("t4_next_latency", 32'(t1 - t0), 3);
    check("t4_next_rsp_write", 32'(rsp_write), 1);
    check("t4_next_rsp_error", 32'(rsp_error), 0);
    check("t4_next_conflict_cnt", 32'(conflict_cnt), 18);
    step();

    // Back-to-back commands with rsp_ready low: buffer fills, order preserved
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send((i % 2) == 0, 12'h400 + 12'(i), 32'hC000_0000 + i, 1'b0, t0);
    end
    check("t5_cmd_ready_full", 32'(cmd_ready), 0);
    check("t5_busy", 32'(busy), 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h405;
    cmd_wdata = 32'h0;
    exp_err   = 1'b0;
    repeat (3) begin
      step();
      check("t5_cmd_ready_held_low", 32'(cmd_ready), 0);
      check("t5_rsp_valid_held", 32'(rsp_valid), 1);
    end
    rsp_ready = 1'b1;
    send(1'b0, 12'h405, 32'h0, 1'b0, t0);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      step();
      k++;
    end
    check("t5_all_responses", 32'(exp_q.size()), 0);
    check("t5_idle_busy", 32'(busy), 0);

    // Reset during WAIT of a write: request and queued command dropped
    allow = 1'b0;
    send(1'b1, 12'h3AB, 32'h1234_5678, 1'b0, t0);
    send(1'b0, 12'h3AC, 32'h0, 1'b0, t2);
    check("t6_second_accept", 32'(t2 - t0), 1);
    step();
    step();
    check("t6_wr_enable_wait", 32'(wr_enable), 1);
    check("t6_wr_addr_wait", 32'(wr_addr), 32'h3AB);
    reset = 1'b1;
    step();
    check("t6_wr_enable_after_reset", 32'(wr_enable), 0);
    check("t6_busy_after_reset", 32'(busy), 0);
    check("t6_rsp_valid_after_reset", 32'(rsp_valid), 0);
    check("t6_cmd_ready_in_reset", 32'(cmd_ready), 0);
    check("t6_conflict_cnt_reset", 32'(conflict_cnt), 0);
    reset = 1'b0;
    allow = 1'b1;
    #1;
    check("t6_cmd_ready_after_reset", 32'(cmd_ready), 1);
    repeat (6) step();
    check("t6_no_response", 32'(rsp_valid), 0);
    check("t6_still_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
